// File: rtl/apb_s.sv
// apb_s : APB completer holding a small register file.
//
// Responds to an APB requester on the same clock. A SETUP cycle latches the
// address, direction and write data. The following ACCESS cycles optionally
// insert wait states before completing. Writes to implemented registers are
// committed at the completion edge. Reads return the register contents in the
// completing cycle. Addresses at or above DEPTH complete with pslverr.
//
// Optional feature macro: APB_S_WAIT_EN
//   defined   : WAIT_CYC wait states are inserted before each completion
//   undefined : zero wait states, WAIT_CYC is ignored
//
// Ports
//   pclk     in   1       bus clock, all state on rising edge
//   presetn  in   1       asynchronous active-low reset
//   psel     in   1       completer select
//   penable  in   1       ACCESS phase indicator
//   pwrite   in   1       1 = write, 0 = read
//   paddr    in   ADDR_W  register address
//   pwdata   in   DATA_W  write data
//   prdata   out  DATA_W  read data, non-zero only in a completing read
//   pready   out  1       completion strobe
//   pslverr  out  1       error response, only while pready=1
//   state_o  out  1       debug view of the FSM: 0 = IDLE, 1 = ACCESS
//
// Handshake: a transfer completes at the rising edge where psel, penable and
// pready are all 1. The requester must hold psel high from SETUP until that
// edge; dropping psel during ACCESS abandons the transfer with no write.

module apb_s #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              state_o
);

`ifdef APB_S_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // Wait counter reload value taken at every SETUP.
  localparam logic [3:0] CNT_LOAD = WAIT_EN ? 4'(WAIT_CYC) : 4'd0;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic in_range;

  assign in_range = int'(addr_q) < DEPTH;

  // Completion is only possible in ACCESS once all wait states are consumed.
  assign pready  = (state_q == S_ACCESS) && (cnt_q == 4'd0) && psel && penable;
  assign pslverr = pready && !in_range;
  assign prdata  = (pready && !wr_q && in_range) ? mem_q[addr_q] : '0;
  assign state_o = state_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Only a genuine SETUP (psel without penable) starts a transfer.
          if (psel && !penable) begin
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            cnt_q   <= CNT_LOAD;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            // Requester walked away: abandon without touching the registers.
            state_q <= S_IDLE;
          end else if (penable) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              if (wr_q && in_range) begin
                mem_q[addr_q] <= wdata_q;
              end
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
